// File: rtl/gps_nav_pkg.sv
// Shared types and constants for the GPS navigation-bit path.
package gps_nav_pkg;

  typedef enum logic {HUNT, LOCK} bitsync_state_t;

  localparam logic [7:0] GPS_PREAMBLE       = 8'b10001011;
  localparam int unsigned GPS_EPOCHS_PER_BIT = 20;

endpackage

// File: rtl/nav_bit_hist.sv
// Transition histogram for bit-edge search: one saturating counter per epoch phase,
// with a threshold-hit flag raised on the increment that reaches LOCK_THRESH.
module nav_bit_hist #(
  parameter int unsigned BINS        = 20,
  parameter int unsigned HIST_W      = 6,
  parameter int unsigned LOCK_THRESH = 8,
  localparam int unsigned IW         = $clog2(BINS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  input  logic [IW-1:0] idx,
  output logic          hit,
  output logic [IW-1:0] hit_idx
);

  localparam logic [HIST_W-1:0] BIN_MAX  = '1;
  localparam logic [HIST_W-1:0] HIT_PREV = HIST_W'(LOCK_THRESH - 1);

  logic [HIST_W-1:0] bins_q [BINS];
  logic [HIST_W-1:0] cur;

  assign cur     = bins_q[idx];
  assign hit     = inc && (cur == HIT_PREV);
  assign hit_idx = idx;

  // NOTE: the bin array is small and must start from zero after reset, so every
  // entry is reset explicitly; large RAM-style arrays would normally be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < BINS; i++) bins_q[i] <= '0;
    end else if (inc && (cur != BIN_MAX)) begin
      bins_q[idx] <= cur + 1'b1;
    end
  end

endmodule

// File: rtl/nav_bit_sync.sv
// Navigation bit synchronizer: histogram-based 20 ms edge search, then integrate-and-dump
// of epoch signs. Optional preamble detector enabled by macro NAV_PREAMBLE_DET_EN.
module nav_bit_sync
  import gps_nav_pkg::*;
#(
  parameter int unsigned EPOCHS_PER_BIT = GPS_EPOCHS_PER_BIT,
  parameter int unsigned HIST_W         = 6,
  parameter int unsigned LOCK_THRESH    = 8,
  parameter int unsigned HUNT_EPOCHS    = 2000,
  parameter int unsigned VOTE_MIN       = 12,
  parameter int unsigned BAD_LIMIT      = 4,
  localparam int unsigned PH_W          = $clog2(EPOCHS_PER_BIT)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            epoch_stb,
  input  logic            sym_in,
  output logic            bit_out,
  output logic            bit_valid,
  output logic            sync_locked,
  output logic [PH_W-1:0] bit_phase,
  output logic            preamble_stb,
  output logic            preamble_inv
);

  localparam int unsigned ACC_W = $clog2(EPOCHS_PER_BIT) + 2;
  localparam int unsigned BAD_W = $clog2(BAD_LIMIT + 1);
  localparam int unsigned HNT_W = $clog2(HUNT_EPOCHS + 1);

  localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(EPOCHS_PER_BIT - 1);
  localparam logic [HNT_W-1:0] HUNT_LAST  = HNT_W'(HUNT_EPOCHS - 1);
  localparam logic [BAD_W-1:0] BAD_LAST   = BAD_W'(BAD_LIMIT - 1);
  localparam logic [ACC_W-1:0] VOTE_LIM   = ACC_W'(VOTE_MIN);

  bitsync_state_t          state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [PH_W-1:0]         bphase_d;
  logic                    skip_q, skip_d;
  logic                    first_q, first_d;
  logic                    prev_q, prev_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] step;
  logic [ACC_W-1:0]        acc_abs;
  logic [BAD_W-1:0]        bad_q, bad_d;
  logic [HNT_W-1:0]        hunt_q, hunt_d;
  logic                    bit_d, valid_d;
  logic                    drop;
  logic                    hist_inc, hist_clr, hist_hit;
  logic [PH_W-1:0]         hist_idx;

  nav_bit_hist #(
    .BINS        (EPOCHS_PER_BIT),
    .HIST_W      (HIST_W),
    .LOCK_THRESH (LOCK_THRESH)
  ) u_hist (
    .clk     (CLK),
    .rst_n   (RST),
    .inc     (hist_inc),
    .clr     (hist_clr),
    .idx     (phase_q),
    .hit     (hist_hit),
    .hit_idx (hist_idx)
  );

  assign step    = sym_in ? ACC_W'(-1) : ACC_W'(1);
  assign acc_abs = acc_q[ACC_W-1] ? -acc_q : acc_q;

  // NOTE: every signal written here gets a default first, so no path through the
  // case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bphase_d = bit_phase;
    skip_d   = skip_q;
    first_d  = first_q;
    prev_d   = prev_q;
    acc_d    = acc_q;
    bad_d    = bad_q;
    hunt_d   = hunt_q;
    bit_d    = bit_out;
    valid_d  = 1'b0;
    drop     = 1'b0;
    hist_inc = 1'b0;
    hist_clr = 1'b0;

    if (epoch_stb) begin
      prev_d  = sym_in;
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;

      unique case (state_q)
        HUNT: begin
          first_d  = 1'b0;
          hist_inc = (sym_in != prev_q) && !first_q;
          if (hist_hit) begin
            state_d  = LOCK;
            bphase_d = hist_idx;
            skip_d   = 1'b1;
            hunt_d   = '0;
          end else if (hunt_q == HUNT_LAST) begin
            hist_clr = 1'b1;
            hunt_d   = '0;
            first_d  = 1'b1;
          end else begin
            hunt_d = hunt_q + 1'b1;
          end
        end

        LOCK: begin
          if (phase_q == bit_phase) begin
            acc_d = step;
            if (skip_q) begin
              // Entry happens mid-bit, so the first dump only holds a partial bit.
              skip_d = 1'b0;
            end else begin
              valid_d = 1'b1;
              bit_d   = acc_q[ACC_W-1];
              if (acc_abs < VOTE_LIM) begin
                if (bad_q == BAD_LAST) drop = 1'b1;
                else                   bad_d = bad_q + 1'b1;
              end else begin
                bad_d = '0;
              end
            end
          end else begin
            acc_d = acc_q + step;
          end

          if (drop) begin
            state_d  = HUNT;
            hist_clr = 1'b1;
            acc_d    = '0;
            bad_d    = '0;
            hunt_d   = '0;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values computed before the edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= HUNT;
      phase_q   <= '0;
      bit_phase <= '0;
      skip_q    <= 1'b0;
      first_q   <= 1'b1;
      prev_q    <= 1'b0;
      acc_q     <= '0;
      bad_q     <= '0;
      hunt_q    <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_phase <= bphase_d;
      skip_q    <= skip_d;
      first_q   <= first_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      bad_q     <= bad_d;
      hunt_q    <= hunt_d;
      bit_out   <= bit_d;
      bit_valid <= valid_d;
    end
  end

  assign sync_locked = (state_q == LOCK);

`ifdef NAV_PREAMBLE_DET_EN
  logic [7:0] pre_sr_q;
  logic [7:0] pre_sr_next;

  // Newest bit enters at the LSB; the match is taken on the updated window.
  assign pre_sr_next = {pre_sr_q[6:0], bit_d};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pre_sr_q     <= '0;
      preamble_stb <= 1'b0;
      preamble_inv <= 1'b0;
    end else begin
      preamble_stb <= 1'b0;
      preamble_inv <= 1'b0;
      if (valid_d) begin
        pre_sr_q <= drop ? '0 : pre_sr_next;
        if (pre_sr_next == GPS_PREAMBLE) begin
          preamble_stb <= 1'b1;
        end else if (pre_sr_next == ~GPS_PREAMBLE) begin
          preamble_stb <= 1'b1;
          preamble_inv <= 1'b1;
        end
      end
    end
  end
`else
  assign preamble_stb = 1'b0;
  assign preamble_inv = 1'b0;
`endif

endmodule

// File: tb/tb_nav_bit_sync.sv
// Self-checking bench for nav_bit_sync against an epoch-level behavioural model.
module tb_nav_bit_sync;

  localparam int EPB    = 20;
  localparam int THR    = 8;
  localparam int HUNT   = 2000;
  localparam int VMIN   = 12;
  localparam int BADLIM = 4;
  localparam int BINMAX = 63;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       epoch_stb = 1'b0;
  logic       sym_in = 1'b0;
  logic       bit_out, bit_valid, sync_locked, preamble_stb, preamble_inv;
  logic [4:0] bit_phase;

  nav_bit_sync dut (
    .CLK          (CLK),
    .RST          (RST),
    .epoch_stb    (epoch_stb),
    .sym_in       (sym_in),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .sync_locked  (sync_locked),
    .bit_phase    (bit_phase),
    .preamble_stb (preamble_stb),
    .preamble_inv (preamble_inv)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int pstb_seen = 0;

  // Behavioural model: histogram of sign changes per epoch phase, list of epoch signs
  // for the bit being integrated, list of decoded bits for the preamble window.
  bit m_locked, m_first, m_skip;
  int m_phase, m_prev, m_hunt, m_bphase, m_bad;
  int m_hist [EPB];
  int m_signs [$];
  bit m_bits [$];
  bit exp_valid, exp_bit, exp_pstb, exp_pinv, have_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_first = 1; m_skip = 0;
    m_phase = 0; m_prev = 0; m_hunt = 0; m_bphase = 0; m_bad = 0;
    foreach (m_hist[i]) m_hist[i] = 0;
    m_signs.delete();
    m_bits.delete();
    exp_valid = 0; exp_bit = 0; exp_pstb = 0; exp_pinv = 0;
  endtask

  function automatic bit window_is(input bit inv);
    logic [7:0] pat;
    int n;
    pat = 8'b10001011;
    n = m_bits.size();
    if (n < 8) return 0;
    for (int i = 0; i < 8; i++)
      if (m_bits[n-8+i] != (pat[7-i] ^ inv)) return 0;
    return 1;
  endfunction

  task automatic model_epoch(input bit s);
    bit lock_now;
    int sum;
    lock_now = 0;
    exp_valid = 0; exp_pstb = 0; exp_pinv = 0;
    if (!m_locked) begin
      if (!m_first && (int'(s) != m_prev)) begin
        if (m_hist[m_phase] < BINMAX) m_hist[m_phase]++;
        if (m_hist[m_phase] == THR) begin
          lock_now = 1; m_locked = 1; m_bphase = m_phase; m_skip = 1;
          m_signs.delete(); m_hunt = 0;
        end
      end
      m_first = 0;
      if (!lock_now) begin
        m_hunt++;
        if (m_hunt == HUNT) begin
          foreach (m_hist[i]) m_hist[i] = 0;
          m_hunt = 0; m_first = 1;
        end
      end
    end else begin
      if (m_phase == m_bphase) begin
        if (m_skip) m_skip = 0;
        else begin
          sum = 0;
          foreach (m_signs[i]) sum += m_signs[i];
          exp_valid = 1;
          exp_bit = (sum < 0);
          m_bits.push_back(exp_bit);
`ifdef NAV_PREAMBLE_DET_EN
          exp_pstb = window_is(0) || window_is(1);
          exp_pinv = window_is(1);
`endif
          if (((sum < 0) ? -sum : sum) < VMIN) m_bad++;
          else m_bad = 0;
          if (m_bad == BADLIM) begin
            m_locked = 0; m_bad = 0; m_hunt = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
            m_bits.delete();
          end
        end
        m_signs.delete();
      end
      m_signs.push_back(s ? -1 : 1);
    end
    m_prev = s;
    m_phase = (m_phase + 1) % EPB;
  endtask

  task automatic compare_outputs();
    if (preamble_stb === 1'b1) pstb_seen++;
    check("bit_valid", bit_valid, exp_valid);
    check("sync_locked", sync_locked, m_locked);
    if (exp_valid) check("bit_out", bit_out, exp_bit);
    if (m_locked) check("bit_phase", bit_phase, m_bphase);
    check("preamble_stb", preamble_stb, exp_pstb);
`ifdef NAV_PREAMBLE_DET_EN
    if (exp_pstb) check("preamble_inv", preamble_inv, exp_pinv);
`else
    check("preamble_inv", preamble_inv, 0);
`endif
  endtask

  // One clock: check what the previous edge produced, then drive this cycle's inputs.
  task automatic step(input bit stb, input bit s);
    @(negedge CLK);
    if (have_exp) compare_outputs();
    if (stb) model_epoch(s);
    else begin exp_valid = 0; exp_pstb = 0; exp_pinv = 0; end
    epoch_stb = stb;
    sym_in = s;
  endtask

  task automatic epoch(input bit s, input int gap);
    step(1, s);
    repeat (gap) step(0, 1'($urandom));
  endtask

  task automatic send_bit(input bit b, input int nflip, input int gap);
    for (int i = 0; i < EPB; i++) epoch((i >= EPB - nflip) ? ~b : b, gap);
  endtask

  task automatic settle();
    step(0, 0);
  endtask

  task automatic do_reset(input bit stb_during);
    @(negedge CLK);
    if (have_exp) compare_outputs();
    RST = 1'b0;
    epoch_stb = stb_during;
    sym_in = 1'($urandom);
    @(negedge CLK);
    check("rst_bit_out", bit_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_locked", sync_locked, 0);
    check("rst_bit_phase", bit_phase, 0);
    check("rst_pre_stb", preamble_stb, 0);
    check("rst_pre_inv", preamble_inv, 0);
    RST = 1'b1;
    epoch_stb = 1'b0;
    model_reset();
    have_exp = 1;
  endtask

  task automatic lock_at_7(input int gap);
    for (int i = 0; i < 7; i++) epoch(0, gap);
    for (int k = 1; k <= 9; k++) send_bit(k[0], 0, gap);
  endtask

  initial begin
    bit b, flip;
    logic [7:0] pre;
    have_exp = 0;
    model_reset();

    // 1: clean bits with edges at phase 7, sparse strobes
    do_reset(0);
    lock_at_7(1);
    settle();
    check("t1_locked", sync_locked, 1);
    check("t1_phase", bit_phase, 7);
    for (int k = 0; k < 12; k++) send_bit(1'($urandom), 0, 1);

    // 3: weak bits (|acc| = 10) drop lock after the fourth
    for (int k = 0; k < 4; k++) send_bit(1'($urandom), 5, 1);
    send_bit(1'($urandom), 0, 1);
    settle();
    check("t3_unlocked", sync_locked, 0);

    // 2: sparse random transitions for 2000 epochs, then show the bins were cleared
    do_reset(0);
    b = 0;
    for (int e = 0; e < HUNT; e++) begin
      flip = (m_hist[m_phase] < 5) && ((m_phase == 3) || ($urandom_range(0, 7) == 0));
      b = b ^ flip;
      epoch(b, 0);
    end
    settle();
    check("t2_hunt", sync_locked, 0);
    for (int e = 0; e < 7 * EPB; e++) begin
      if (m_phase == 3) b = ~b;
      epoch(b, 0);
    end
    settle();
    check("t2_cleared", sync_locked, 0);
    for (int e = 0; e < EPB; e++) begin
      if (m_phase == 3) b = ~b;
      epoch(b, 0);
    end
    settle();
    check("t2_lock", sync_locked, 1);
    check("t2_phase", bit_phase, 3);

    // 4: reset mid-bit while locked, then re-lock from scratch
    do_reset(0);
    lock_at_7(1);
    send_bit(1'($urandom), 0, 1);
    send_bit(1'($urandom), 0, 1);
    for (int i = 0; i < 10; i++) epoch(1'($urandom), 1);
    do_reset(1);
    for (int i = 0; i < 7; i++) epoch(0, 1);
    for (int k = 1; k <= 7; k++) send_bit(k[0], 0, 1);
    settle();
    check("t4_seven", sync_locked, 0);
    send_bit(0, 0, 1);
    settle();
    check("t4_relock", sync_locked, 1);

    // 5: preamble then inverted preamble as the first decoded bits
    pstb_seen = 0;
    pre = 8'b10001011;
    for (int i = 7; i >= 0; i--) send_bit(pre[i], 0, 1);
    for (int i = 7; i >= 0; i--) send_bit(~pre[i], 0, 1);
    send_bit(0, 0, 1);
    settle();
`ifdef NAV_PREAMBLE_DET_EN
    check("t5_pre_count", pstb_seen, 2);
`else
    check("t5_pre_count", pstb_seen, 0);
`endif

    // 6: back-to-back strobes
    do_reset(0);
    lock_at_7(0);
    for (int k = 0; k < 6; k++) send_bit(1'($urandom), 0, 0);
    settle();
    check("t6_locked", sync_locked, 1);
    check("t6_phase", bit_phase, 7);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
